// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel input block: the write-handshake
// state encoding and the default key debounce length.
package panel_pkg;

    // Consecutive stable cycles needed before a key level change is accepted.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

    // IDLE accepts key presses; WAIT_ACK holds a memory write until acknowledged.
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } panel_state_t;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton conditioner: 2-flop synchronizer, debounce counter, and a
// single-cycle press pulse on each accepted high-to-low (press) transition.
// Keys are active-low, so the released level is 1.
module key_debounce
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic panel_clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);

    localparam logic [15:0] COUNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync_1;
    logic        sync_2;
    logic        stable;
    logic        stable_d1;
    logic [15:0] count;

    // Bring the raw key into the clock domain; reset treats every key as released.
    always_ff @(posedge panel_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= key_raw;
            sync_2 <= sync_1;
        end
    end

    // Count consecutive disagreeing cycles; any agreeing cycle restarts the count.
    always_ff @(posedge panel_clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b1;
            count  <= '0;
        end else if (sync_2 == stable) begin
            count <= '0;
        end else if (count == COUNT_LAST) begin
            stable <= sync_2;
            count  <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

    // Registered edge detect: pulse only when the stable level falls (press), never on release.
    always_ff @(posedge panel_clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d1 <= 1'b1;
            press     <= 1'b0;
        end else begin
            stable_d1 <= stable;
            press     <= stable_d1 & ~stable;
        end
    end

endmodule

// File: rtl/panel_input.sv
// Front-panel loader: three debounced keys set a memory address, write a data
// byte through a req/ack handshake, or request a CPU run.
// Optional feature macro: PANEL_AUTOINC_EN -- when defined, each completed
// write also advances load_addr (wrapping 0xFF -> 0x00).
module panel_input
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       panel_clk,
    input  logic       rst_n,
    input  logic [7:0] SW,
    input  logic       KEY_addr,
    input  logic       KEY_data,
    input  logic       KEY_run,
    input  logic       mem_wr_ack,
    output logic [7:0] load_addr,
    output logic [7:0] load_data,
    output logic       mem_wr_req,
    output logic       load_busy,
    output logic       run_req,
    output logic [7:0] wr_count
);

`ifdef PANEL_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    panel_state_t state;
    logic         addr_press;
    logic         data_press;
    logic         run_press;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_addr (
        .panel_clk (panel_clk),
        .rst_n     (rst_n),
        .key_raw   (KEY_addr),
        .press     (addr_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_data (
        .panel_clk (panel_clk),
        .rst_n     (rst_n),
        .key_raw   (KEY_data),
        .press     (data_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_run (
        .panel_clk (panel_clk),
        .rst_n     (rst_n),
        .key_raw   (KEY_run),
        .press     (run_press)
    );

    assign load_busy = (state == WAIT_ACK);

    // Panel FSM: presses act only in IDLE (data > addr > run), a write parks in WAIT_ACK until acked.
    always_ff @(posedge panel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            load_addr  <= 8'h00;
            load_data  <= 8'h00;
            mem_wr_req <= 1'b0;
            run_req    <= 1'b0;
            wr_count   <= 8'h00;
        end else begin
            run_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_press) begin
                        load_data  <= SW;
                        mem_wr_req <= 1'b1;
                        state      <= WAIT_ACK;
                    end else if (addr_press) begin
                        load_addr <= SW;
                    end else if (run_press) begin
                        run_req <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (mem_wr_ack) begin
                        mem_wr_req <= 1'b0;
                        wr_count   <= wr_count + 8'd1;
                        if (AUTOINC) begin
                            load_addr <= load_addr + 8'd1;
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_panel_input.sv
// Scoreboard bench for panel_input: key operations are issued at a high level
// (which keys, how long held, when memory acks), the expected output events
// are queued with their cycle, and a monitor pops them as the DUT shows them.
// Honours PANEL_AUTOINC_EN the same way the design does.
module tb_panel_input;

    localparam int DB = 16;

`ifdef PANEL_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam int EV_RUN   = 1;
    localparam int EV_WREQ  = 2;
    localparam int EV_WDONE = 3;
    localparam int EV_ADDR  = 4;
    localparam int EV_DATA  = 5;
    localparam int EV_COUNT = 6;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] count;
        logic       busy;
    } exp_t;

    logic       panel_clk = 1'b0;
    logic       rst_n;
    logic [7:0] SW;
    logic       KEY_addr;
    logic       KEY_data;
    logic       KEY_run;
    logic       mem_wr_ack;
    logic [7:0] load_addr;
    logic [7:0] load_data;
    logic       mem_wr_req;
    logic       load_busy;
    logic       run_req;
    logic [7:0] wr_count;

    int   cyc = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;
    exp_t exp_q[$];

    logic [7:0] m_addr;
    logic [7:0] m_data;
    logic [7:0] m_count;

    logic [7:0] p_addr;
    logic [7:0] p_data;
    logic [7:0] p_count;
    logic       p_req;

    panel_input #(.DEBOUNCE_CYCLES(DB)) dut (
        .panel_clk  (panel_clk),
        .rst_n      (rst_n),
        .SW         (SW),
        .KEY_addr   (KEY_addr),
        .KEY_data   (KEY_data),
        .KEY_run    (KEY_run),
        .mem_wr_ack (mem_wr_ack),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .mem_wr_req (mem_wr_req),
        .load_busy  (load_busy),
        .run_req    (run_req),
        .wr_count   (wr_count)
    );

    always #5 panel_clk = ~panel_clk;

    always @(posedge panel_clk) cyc <= cyc + 1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expectEvent(input int kind, input int at);
        exp_t e;
        e.kind  = kind;
        e.cyc   = at;
        e.addr  = m_addr;
        e.data  = m_data;
        e.count = m_count;
        e.busy  = (kind == EV_WREQ);
        exp_q.push_back(e);
    endtask

    // mask bit0 = addr key, bit1 = data key, bit2 = run key, all pressed together.
    // A key is accepted once it has been sampled low DB times in a row; its action
    // lands DB+3 edges after the first low sample. An ack is always pulsed at
    // ack_edge; when no write is outstanding it must be ignored.
    task automatic applyStimulus(input logic [2:0] mask, input logic [7:0] sw, input int hold,
                                 input int ack_delay, input bit run_in_wait);
        int first;
        int ev;
        int ack_edge;
        int run_first;
        int end_cyc;
        int c;
        bit accepted;
        bit is_write;
        @(negedge panel_clk);
        SW        = sw;
        first     = cyc + 1;
        ev        = first + DB + 3;
        accepted  = (hold >= DB) && (mask != 3'b000);
        is_write  = accepted && mask[1];
        if (is_write && run_in_wait && ack_delay < DB + 8) ack_delay = DB + 8;
        ack_edge  = ev + ack_delay;
        run_first = ev + 2;
        if (accepted) begin
            if (mask[1]) begin
                m_data = sw;
                expectEvent(EV_WREQ, ev);
                m_count = m_count + 8'd1;
                if (AUTOINC) m_addr = m_addr + 8'd1;
                expectEvent(EV_WDONE, ack_edge);
            end else if (mask[0]) begin
                m_addr = sw;
                expectEvent(EV_ADDR, ev);
            end else begin
                expectEvent(EV_RUN, ev);
            end
        end
        end_cyc = max2(first + hold + DB + 6, ack_edge + 2);
        if (is_write && run_in_wait) end_cyc = max2(end_cyc, run_first + 2 * DB + 8);
        while (cyc < end_cyc) begin
            c          = cyc + 1;
            KEY_addr   = !(mask[0] && (c < first + hold));
            KEY_data   = !(mask[1] && (c < first + hold));
            KEY_run    = !((mask[2] && (c < first + hold)) ||
                           (is_write && run_in_wait && c >= run_first && c < run_first + DB + 2));
            mem_wr_ack = (c == ack_edge);
            if (c > ev) SW = 8'($urandom);
            @(negedge panel_clk);
        end
        KEY_addr   = 1'b1;
        KEY_data   = 1'b1;
        KEY_run    = 1'b1;
        mem_wr_ack = 1'b0;
    endtask

    // Monitor: classify any visible output change as one event and match it against the queue.
    always @(negedge panel_clk) begin
        int   kind;
        exp_t e;
        if (!rst_n) begin
            p_addr  = load_addr;
            p_data  = load_data;
            p_count = wr_count;
            p_req   = mem_wr_req;
        end else begin
            kind = 0;
            if (mem_wr_req && !p_req)         kind = EV_WREQ;
            else if (!mem_wr_req && p_req)    kind = EV_WDONE;
            else if (run_req)                 kind = EV_RUN;
            else if (load_addr !== p_addr)    kind = EV_ADDR;
            else if (load_data !== p_data)    kind = EV_DATA;
            else if (wr_count !== p_count)    kind = EV_COUNT;
            if (kind != 0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_event", 64'(kind), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("event_kind_cycle", {32'(kind), 32'(cyc)}, {32'(e.kind), 32'(e.cyc)});
                    checkOutput("event_values", {39'd0, load_addr, load_data, wr_count, load_busy},
                                {39'd0, e.addr, e.data, e.count, e.busy});
                end
            end
            p_addr  = load_addr;
            p_data  = load_data;
            p_count = wr_count;
            p_req   = mem_wr_req;
        end
    end

    // Hard stop in case the run never reaches its summary.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: time limit reached, expected the run to finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int       first;
        int       ev;
        int       op;
        int       hold;
        int       ack;
        bit       riw;
        logic [2:0] mask;

        rst_n      = 1'b1;
        SW         = 8'h00;
        KEY_addr   = 1'b1;
        KEY_data   = 1'b1;
        KEY_run    = 1'b1;
        mem_wr_ack = 1'b0;
        m_addr     = 8'h00;
        m_data     = 8'h00;
        m_count    = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_outputs", {40'd0, load_addr, load_data, wr_count, mem_wr_req, run_req, load_busy, 5'd0},
                    64'd0);
        repeat (3) @(negedge panel_clk);
        #2 rst_n = 1'b1;
        $display("[TB] reset released, starting directed scenarios");

        // Short glitches on the data key must never start a write.
        for (int i = 0; i < 5; i++) applyStimulus(3'b010, 8'($urandom), 10, 4, 1'b0);

        applyStimulus(3'b001, 8'h3C, 30, 5, 1'b0);
        applyStimulus(3'b010, 8'hA5, DB + 2, 7, 1'b0);
        applyStimulus(3'b001, 8'hFF, DB, 3, 1'b0);
        applyStimulus(3'b010, 8'h77, DB + 1, 2, 1'b0);
        applyStimulus(3'b010, 8'h11, DB, DB + 10, 1'b1);
        applyStimulus(3'b100, 8'h00, DB + 3, 5, 1'b0);
        applyStimulus(3'b111, 8'h42, DB + 4, 3, 1'b0);
        applyStimulus(3'b101, 8'h24, DB + 4, 3, 1'b0);

        $display("[TB] randomized operations");
        for (int i = 0; i < 50; i++) begin
            op   = int'($urandom_range(0, 4));
            hold = DB + int'($urandom_range(0, 14));
            ack  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : DB + int'($urandom_range(8, 14));
            riw  = ($urandom_range(0, 3) == 0);
            case (op)
                0: begin
                    mask = 3'($urandom_range(1, 7));
                    hold = int'($urandom_range(1, DB - 1));
                end
                1: mask = 3'b001;
                2: mask = 3'b010;
                3: mask = 3'b100;
                default: begin
                    case ($urandom_range(0, 3))
                        0: mask = 3'b011;
                        1: mask = 3'b101;
                        2: mask = 3'b110;
                        default: mask = 3'b111;
                    endcase
                end
            endcase
            applyStimulus(mask, 8'($urandom), hold, ack, riw);
        end

        $display("[TB] reset during an outstanding write");
        @(negedge panel_clk);
        SW       = 8'hC3;
        KEY_data = 1'b0;
        first    = cyc + 1;
        ev       = first + DB + 3;
        m_data   = 8'hC3;
        expectEvent(EV_WREQ, ev);
        while (cyc + 1 < first + DB) @(negedge panel_clk);
        KEY_data = 1'b1;
        while (cyc < ev + 4) @(negedge panel_clk);
        KEY_addr = 1'b0;
        SW       = 8'h5A;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_wait", {40'd0, load_addr, load_data, wr_count, mem_wr_req, run_req, load_busy, 5'd0},
                    64'd0);
        m_addr  = 8'h00;
        m_data  = 8'h00;
        m_count = 8'h00;
        repeat (3) @(negedge panel_clk);
        #2 rst_n = 1'b1;
        first  = cyc + 1;
        m_addr = 8'h5A;
        expectEvent(EV_ADDR, first + DB + 3);
        @(negedge panel_clk);
        mem_wr_ack = 1'b1;
        @(negedge panel_clk);
        mem_wr_ack = 1'b0;
        while (cyc < first + DB + 8) @(negedge panel_clk);
        KEY_addr = 1'b1;
        repeat (DB + 6) @(negedge panel_clk);

        $display("[TB] filling wr_count up to its wrap");
        while (m_count != 8'hFF) applyStimulus(3'b010, 8'($urandom), DB, int'($urandom_range(1, 4)), 1'b0);
        applyStimulus(3'b001, 8'hFF, DB, 2, 1'b0);
        applyStimulus(3'b010, 8'h99, DB, 3, 1'b0);
        applyStimulus(3'b100, 8'h00, DB, 3, 1'b0);

        repeat (2 * DB) @(negedge panel_clk);
        checkOutput("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/panel_input.md
PANEL_INPUT -- requirements
Module: panel_input

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the consecutive stable cycles required to accept a key level change (legal range 2..65535).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port panel_clk: input, 1 bit, panel clock.
REQ-004 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-005 Port SW: input, 8 bits, board switches, the address/data value.
REQ-006 Port KEY_addr: input, 1 bit, raw pushbutton, active-low, latches the address.
REQ-007 Port KEY_data: input, 1 bit, raw pushbutton, active-low, latches data and starts a memory write.
REQ-008 Port KEY_run: input, 1 bit, raw pushbutton, active-low, requests CPU run.
REQ-009 Port mem_wr_ack: input, 1 bit, memory write-complete acknowledge.
REQ-010 Port load_addr: output, 8 bits, memory write address, which also drives the MAR display.
REQ-011 Port load_data: output, 8 bits, memory write data.
REQ-012 Port mem_wr_req: output, 1 bit, memory write request.
REQ-013 Port load_busy: output, 1 bit, high while a write is outstanding.
REQ-014 Port run_req: output, 1 bit, single-cycle CPU run pulse.
REQ-015 Port wr_count: output, 8 bits, count of completed writes, wrapping.

Function
REQ-016 Each key SHALL pass through a 2-flop synchronizer, then a debounce counter; the stable level SHALL flip only after DEBOUNCE_CYCLES consecutive cycles where the synchronized level differs from the stable level.
REQ-017 Any cycle where the synchronized level equals the stable level SHALL clear that key's counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
REQ-018 A stable high-to-low transition SHALL produce exactly one 1-cycle press pulse.
- The pulse SHALL occur DEBOUNCE_CYCLES+2 cycles after the first edge sampling the raw key low.
- The release transition SHALL produce no pulse.
REQ-019 The FSM SHALL have states IDLE and WAIT_ACK.
REQ-020 In IDLE, an addr press SHALL load SW into load_addr on the next edge.
REQ-021 In IDLE, a data press SHALL load SW into load_data, set mem_wr_req=1, and enter WAIT_ACK on the next edge.
REQ-022 In IDLE, a run press SHALL drive run_req=1 for exactly one cycle.
REQ-023 Same-cycle presses in IDLE SHALL resolve by priority data > addr > run; the lower-priority presses SHALL be dropped.
REQ-024 In WAIT_ACK, mem_wr_req SHALL stay high with load_addr and load_data held constant until mem_wr_ack is sampled high.
REQ-025 On that edge in WAIT_ACK:
- mem_wr_req SHALL be cleared;
- wr_count SHALL increment, with 0xFF wrapping to 0x00;
- the FSM SHALL return to IDLE.
REQ-026 All presses arriving while in WAIT_ACK SHALL be discarded, not queued.
REQ-027 mem_wr_ack sampled high in IDLE SHALL be ignored.
REQ-028 load_busy SHALL equal (state == WAIT_ACK).

Reset
REQ-029 Asserting rst_n low SHALL immediately force:
- IDLE;
- load_addr=0x00, load_data=0x00, wr_count=0x00;
- mem_wr_req=0, run_req=0;
- all debounce counters=0, all stable levels=1 (released), all synchronizer flops=1.
REQ-030 Reset mid-WAIT_ACK SHALL abandon the write; no pulse SHALL be generated by keys already held low at reset release until they pass debounce.

Configuration
REQ-031 With PANEL_AUTOINC_EN defined, a completed write SHALL also increment load_addr on the ack edge, with 0xFF wrapping to 0x00.
REQ-032 Without PANEL_AUTOINC_EN, load_addr SHALL change only on an addr press.

Structure
REQ-033 Package panel_pkg SHALL hold the FSM state enum (IDLE, WAIT_ACK) and the default DEBOUNCE_CYCLES constant.
REQ-034 Sub-module key_debounce (synchronizer, counter, press pulse) SHALL be instantiated three times.

Verification
REQ-035 The bench SHALL cover the following directed scenarios (DEBOUNCE_CYCLES=16):
- KEY_data low pulses of 10 cycles, repeated 5 times -> no press, mem_wr_req stays 0.
- SW=0x3C, KEY_addr held low 30 cycles -> load_addr=0x3C 19 cycles after the first low sample, exactly once.
- SW=0xA5, KEY_data press, ack after 7 cycles -> mem_wr_req high 7 cycles with load_data=0xA5, wr_count=1; load_addr+1 only with PANEL_AUTOINC_EN.
- AUTOINC, load_addr=0xFF, one write -> load_addr=0x00; with wr_count=0xFF -> wr_count=0x00.
- KEY_run press during WAIT_ACK -> run_req never asserts; same press in IDLE -> one 1-cycle run_req.
- rst_n low 3 cycles mid-WAIT_ACK -> all outputs 0, state IDLE; a later ack is ignored.
